// File: rtl/pu_sci_table_ctrl.sv
// pu_sci_table_ctrl
//   Write controller for the RCI->SCI translation table. Buffers ASA table
//   updates in a small FIFO, arbitrates them round-robin against PIO writes,
//   and runs a clear sweep of the whole table after reset or on start_init.
//   At most one table write is issued per cycle.
//
// Ports
//   clk, rstn                 clock, synchronous active-low reset
//   asa_wr/asa_waddr/wdata    ASA update push into the FIFO
//   asa_full, asa_ovf         FIFO full (registered), sticky drop flag
//   ovf_clr                   clears asa_ovf (a simultaneous drop wins)
//   pio_wr_req/waddr/wdata    level PIO write request, held until acked
//   pio_wr_ack                one-cycle pulse with the PIO table write
//   start_init                pulse, (re)starts the clear sweep
//   init_busy, init_done      sweep in progress / pulse with last clear write
//   table_wr/waddr/wdata      registered table write port

`ifndef RCI_NBITS
`define RCI_NBITS 4
`endif
`ifndef SCI_NBITS
`define SCI_NBITS 8
`endif

module pu_sci_table_ctrl #(
  parameter int unsigned RCI_NBITS        = `RCI_NBITS,
  parameter int unsigned SCI_NBITS        = `SCI_NBITS,
  parameter int unsigned FIFO_DEPTH_NBITS = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 asa_wr,
  input  logic [RCI_NBITS-1:0] asa_waddr,
  input  logic [SCI_NBITS-1:0] asa_wdata,
  output logic                 asa_full,
  output logic                 asa_ovf,
  input  logic                 ovf_clr,
  input  logic                 pio_wr_req,
  input  logic [RCI_NBITS-1:0] pio_waddr,
  input  logic [SCI_NBITS-1:0] pio_wdata,
  output logic                 pio_wr_ack,
  input  logic                 start_init,
  output logic                 init_busy,
  output logic                 init_done,
  output logic                 table_wr,
  output logic [RCI_NBITS-1:0] table_waddr,
  output logic [SCI_NBITS-1:0] table_wdata
);

  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_NBITS;
  localparam logic [FIFO_DEPTH_NBITS:0] DEPTH_C = {1'b1, {FIFO_DEPTH_NBITS{1'b0}}};

  typedef enum logic {INIT, RUN} state_t;

  state_t                      state;
  logic [RCI_NBITS-1:0]        init_addr;
  logic [RCI_NBITS-1:0]        fifo_addr [DEPTH];
  logic [SCI_NBITS-1:0]        fifo_data [DEPTH];
  logic [FIFO_DEPTH_NBITS-1:0] wptr;
  logic [FIFO_DEPTH_NBITS-1:0] rptr;
  logic [FIFO_DEPTH_NBITS:0]   count;
  logic [FIFO_DEPTH_NBITS:0]   count_nxt;
  logic                        last_pio;
  logic                        asa_req;
  logic                        pio_req;
  logic                        grant_asa;
  logic                        grant_pio;
  logic                        push;
  logic                        pop;
  logic                        drop;

  always_comb begin
    asa_req   = (count != '0);
    // A request still held during its ack cycle is the one just served.
    pio_req   = pio_wr_req && !pio_wr_ack;
    grant_asa = 1'b0;
    grant_pio = 1'b0;
    if (state == RUN && !start_init) begin
      if (asa_req && pio_req) begin
        grant_pio = !last_pio;
        grant_asa = last_pio;
      end else begin
        grant_asa = asa_req;
        grant_pio = pio_req;
      end
    end
    pop  = grant_asa;
    push = asa_wr && (!asa_full || pop);
    drop = asa_wr && asa_full && !pop;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wptr] <= asa_waddr;
      fifo_data[wptr] <= asa_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= INIT;
      init_addr   <= '0;
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      asa_full    <= 1'b0;
      asa_ovf     <= 1'b0;
      last_pio    <= 1'b1;
      table_wr    <= 1'b0;
      table_waddr <= '0;
      table_wdata <= '0;
      pio_wr_ack  <= 1'b0;
      init_done   <= 1'b0;
      init_busy   <= 1'b1;
    end else begin
      table_wr   <= 1'b0;
      pio_wr_ack <= 1'b0;
      init_done  <= 1'b0;
      // Lags the state by one cycle so it stays high through init_done.
      init_busy  <= (state == INIT) || start_init;

      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count    <= count_nxt;
      asa_full <= (count_nxt == DEPTH_C);

      if (drop)         asa_ovf <= 1'b1;
      else if (ovf_clr) asa_ovf <= 1'b0;

      if (start_init) begin
        state     <= INIT;
        init_addr <= '0;
      end else if (state == INIT) begin
        table_wr    <= 1'b1;
        table_waddr <= init_addr;
        table_wdata <= '0;
        init_addr   <= init_addr + 1'b1;
        if (init_addr == '1) begin
          init_done <= 1'b1;
          state     <= RUN;
        end
      end else if (grant_asa) begin
        table_wr    <= 1'b1;
        table_waddr <= fifo_addr[rptr];
        table_wdata <= fifo_data[rptr];
        last_pio    <= 1'b0;
      end else if (grant_pio) begin
        table_wr    <= 1'b1;
        table_waddr <= pio_waddr;
        table_wdata <= pio_wdata;
        pio_wr_ack  <= 1'b1;
        last_pio    <= 1'b1;
      end
    end
  end

endmodule
